// File: rtl/regfile_branch_pc.sv
// regfile_branch_pc: parametrised register file with bypassed reads, equality
// compare and a program counter that steps, branches or stalls.
//
// Ports:
//   Clock         rising-edge clock
//   Reset_n       asynchronous active-low reset (registers 0, PC_out = RESET_PC)
//   RS, RT        read indices for operands A and B
//   RD            write index
//   WriteData     write data
//   RegWrite      write enable (never blocked by Stall)
//   ReadRS/ReadRT combinational operands, bypassed from WriteData on RD match
//   Branch        branch-if-equal request
//   BranchOffset  signed byte offset, sign-extended to PC_WIDTH
//   Stall         hold PC this cycle
//   Equal         combinational ReadRS == ReadRT
//   PC_out        registered program counter
//   BranchTaken   registered, high for the cycle after a taken branch
//
// Optional feature: define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_branch_pc #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2,
    parameter int PC_WIDTH = 16,
    parameter int PC_STEP = 2,
    parameter int OFFSET_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic [ADDR_WIDTH-1:0]   RS,
    input  logic [ADDR_WIDTH-1:0]   RT,
    input  logic [ADDR_WIDTH-1:0]   RD,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    input  logic                    RegWrite,
    output logic [DATA_WIDTH-1:0]   ReadRS,
    output logic [DATA_WIDTH-1:0]   ReadRT,
    input  logic                    Branch,
    input  logic [OFFSET_WIDTH-1:0] BranchOffset,
    input  logic                    Stall,
    output logic                    Equal,
    output logic [PC_WIDTH-1:0]     PC_out,
    output logic                    BranchTaken
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_en;
    logic [PC_WIDTH-1:0]   offset_ext;
    logic                  taken;

    // Gating the write enable also gates the bypass, so register 0 stays
    // zero both in storage and on the read path when the feature is on.
`ifdef REGFILE_ZERO_REG_EN
    assign wr_en = RegWrite && (RD != '0);
`else
    assign wr_en = RegWrite;
`endif

    assign ReadRS     = (wr_en && RD == RS) ? WriteData : regs[RS];
    assign ReadRT     = (wr_en && RD == RT) ? WriteData : regs[RT];
    assign Equal      = ReadRS == ReadRT;
    assign offset_ext = PC_WIDTH'($signed(BranchOffset));
    assign taken      = Branch && Equal;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[RD] <= WriteData;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            PC_out      <= RESET_PC;
            BranchTaken <= 1'b0;
        end else begin
            PC_out      <= Stall ? PC_out : taken ? PC_out + offset_ext : PC_out + PC_WIDTH'(PC_STEP);
            BranchTaken <= !Stall && taken;
        end
    end
endmodule
